// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants for the PC / return-address-stack block.
//   icode values (I_*) and status codes (STAT_*), plus a small decode helper.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // icodes C..F are not part of the instruction set
    function automatic logic is_bad_icode(input logic [3:0] ic);
        return ic[3] & ic[2];
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, rst_n   : clock, synchronous active-low reset (pointer/count only)
//   push, pop    : one-cycle strobes; push wins if both are asserted
//   push_data    : return address written on push
//   top          : most recent entry, 0 when empty (combinational)
//   count        : number of valid entries, saturates at DEPTH
//   overflow     : registered pulse, a push overwrote the oldest entry
module ras_stack
    import y86_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              push_data,
    output logic [W-1:0]              top,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] wp_m1;
    logic          full;
    logic          empty;

    assign wp_m1 = wp - PW'(1);
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign top   = empty ? '0 : mem[wp_m1];

    // Entries carry no reset; count gates their visibility.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wp] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (push) begin
                wp <= wp + PW'(1);
                if (full)
                    overflow <= 1'b1;
                else
                    count <= count + CW'(1);
            end else if (pop && !empty) begin
                // popping an empty stack is tolerated and changes nothing
                wp    <= wp_m1;
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: Y86-64 next-PC register with return-address-stack checking.
//   Inputs : clk, rst_n (sync, active low), stall, icode, cnd, val_m, val_c,
//            val_p, stat
//   Outputs: pc, halted (sticky), bad_icode / ret_valid / ret_hit /
//            ras_overflow (one-cycle pulses), ras_top, ras_count,
//            ret_total / ret_hits (perf counters)
//   Build option: define RAS_PERF_EN to build the ret/ret-hit counters;
//   otherwise both counter ports read 0.
module pc_ras_unit
    import y86_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic [3:0]                   icode,
    input  logic                         cnd,
    input  logic [ADDR_W-1:0]            val_m,
    input  logic [ADDR_W-1:0]            val_c,
    input  logic [ADDR_W-1:0]            val_p,
    input  logic [2:0]                   stat,
    output logic [ADDR_W-1:0]            pc,
    output logic                         halted,
    output logic                         bad_icode,
    output logic [ADDR_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ret_valid,
    output logic                         ret_hit,
    output logic                         ras_overflow,
    output logic [31:0]                  ret_total,
    output logic [31:0]                  ret_hits
);

    logic              upd;
    logic              do_call;
    logic              do_ret;
    logic              hit_now;
    logic [ADDR_W-1:0] pc_nxt;

    // A non-AOK status freezes the block just like a stall.
    assign upd     = rst_n & ~stall & (stat == STAT_AOK) & ~halted;
    assign do_call = upd & (icode == I_CALL);
    assign do_ret  = upd & (icode == I_RET);
    // The empty-stack top reads 0, so the hit must also require an entry.
    assign hit_now = do_ret & (ras_count != '0) & (ras_top == val_m);

    always_comb begin
        pc_nxt = pc;
        unique case (icode)
            I_JXX:   pc_nxt = cnd ? val_c : val_p;
            I_CALL:  pc_nxt = val_c;
            I_RET:   pc_nxt = val_m;
            4'hC, 4'hD, 4'hE, 4'hF: pc_nxt = pc;
            default: pc_nxt = val_p;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            halted    <= 1'b0;
            bad_icode <= 1'b0;
            ret_valid <= 1'b0;
            ret_hit   <= 1'b0;
        end else begin
            bad_icode <= 1'b0;
            ret_valid <= 1'b0;
            ret_hit   <= 1'b0;
            if (upd) begin
                pc        <= pc_nxt;
                halted    <= (icode == I_HALT);
                bad_icode <= is_bad_icode(icode);
                ret_valid <= do_ret;
                ret_hit   <= hit_now;
            end
        end
    end

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (do_call),
        .pop       (do_ret),
        .push_data (val_p),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow)
    );

`ifdef RAS_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_total <= '0;
            ret_hits  <= '0;
        end else begin
            if (do_ret)
                ret_total <= ret_total + 32'd1;
            if (hit_now)
                ret_hits <= ret_hits + 32'd1;
        end
    end
`else
    assign ret_total = '0;
    assign ret_hits  = '0;
`endif

endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit: scoreboard bench for pc_ras_unit. Each driven cycle
// pushes the expected post-edge outputs from a queue-based stack model;
// the entry is popped and compared one edge later.
module tb_pc_ras_unit;
    import y86_pkg::*;

    localparam int              AW    = 64;
    localparam int              DEPTH = 8;
    localparam logic [AW-1:0]   RPC   = 64'h1000;

    logic            clk = 1'b0;
    logic            rst_n, stall, cnd;
    logic [3:0]      icode;
    logic [AW-1:0]   val_m, val_c, val_p;
    logic [2:0]      stat;
    logic [AW-1:0]   pc, ras_top;
    logic            halted, bad_icode, ret_valid, ret_hit, ras_overflow;
    logic [3:0]      ras_count;
    logic [31:0]     ret_total, ret_hits;

    always #5 clk = ~clk;

    pc_ras_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .icode(icode), .cnd(cnd),
        .val_m(val_m), .val_c(val_c), .val_p(val_p), .stat(stat),
        .pc(pc), .halted(halted), .bad_icode(bad_icode), .ras_top(ras_top),
        .ras_count(ras_count), .ret_valid(ret_valid), .ret_hit(ret_hit),
        .ras_overflow(ras_overflow), .ret_total(ret_total), .ret_hits(ret_hits)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic          halted, bad, rv, rh, ov;
        logic [AW-1:0] top;
        logic [3:0]    cnt;
        logic [31:0]   tot, hits;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_pass = 0;

    // reference state
    logic [AW-1:0] m_pc;
    logic          m_halt;
    logic [AW-1:0] m_stk[$];
    logic [31:0]   m_tot, m_hits;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    endtask

    task automatic step(input bit r, input bit s, input logic [3:0] ic, input bit c,
                        input logic [AW-1:0] vm, input logic [AW-1:0] vc,
                        input logic [AW-1:0] vp, input logic [2:0] st);
        exp_t e;
        rst_n = r; stall = s; icode = ic; cnd = c;
        val_m = vm; val_c = vc; val_p = vp; stat = st;
        e.bad = 0; e.rv = 0; e.rh = 0; e.ov = 0;
        if (!r) begin
            m_pc = RPC; m_halt = 0; m_stk.delete(); m_tot = 0; m_hits = 0;
        end else if (!s && st == 3'd1 && !m_halt) begin
            case (ic)
                4'h0: begin m_pc = vp; m_halt = 1; end
                4'h7: m_pc = c ? vc : vp;
                4'h8: begin
                    m_pc = vc;
                    if (m_stk.size() == DEPTH) begin void'(m_stk.pop_front()); e.ov = 1; end
                    m_stk.push_back(vp);
                end
                4'h9: begin
                    m_pc = vm; e.rv = 1; m_tot++;
                    if (m_stk.size() > 0) begin
                        e.rh = (m_stk[$] == vm);
                        void'(m_stk.pop_back());
                    end
                    if (e.rh) m_hits++;
                end
                4'hC, 4'hD, 4'hE, 4'hF: e.bad = 1;
                default: m_pc = vp;
            endcase
        end
        e.pc = m_pc; e.halted = m_halt;
        e.top = (m_stk.size() > 0) ? m_stk[$] : '0;
        e.cnt = 4'(m_stk.size());
`ifdef RAS_PERF_EN
        e.tot = m_tot; e.hits = m_hits;
`else
        e.tot = 0; e.hits = 0;
`endif
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("halted", halted, e.halted);
            chk("bad_icode", bad_icode, e.bad);
            chk("ret_valid", ret_valid, e.rv);
            chk("ret_hit", ret_hit, e.rh);
            chk("ras_overflow", ras_overflow, e.ov);
            chk("ras_top", ras_top, e.top);
            chk("ras_count", ras_count, e.cnt);
            chk("ret_total", ret_total, e.tot);
            chk("ret_hits", ret_hits, e.hits);
        end
    endtask

    task automatic nop_op(input logic [3:0] ic, input logic [AW-1:0] vm,
                          input logic [AW-1:0] vc, input logic [AW-1:0] vp);
        step(1, 0, ic, 0, vm, vc, vp, 3'd1);
    endtask

    initial begin
        // reset and basic sequencing
        step(0, 0, I_NOP, 0, 0, 0, 0, 3'd1);
        chk("tp_reset_pc", pc, RPC);
        nop_op(I_NOP, 0, 0, 64'h0A);
        chk("tp_pc_0A", pc, 64'h0A);
        step(0, 0, I_CALL, 0, 0, 64'h200, 64'h33, 3'd1);
        chk("tp_rst_call_pc", pc, RPC);
        chk("tp_rst_call_cnt", ras_count, 0);

        // conditional jump and stall
        step(1, 0, I_JXX, 0, 0, 64'h100, 64'h0B, 3'd1);
        chk("tp_jxx_nt", pc, 64'h0B);
        step(1, 0, I_JXX, 1, 0, 64'h100, 64'h0B, 3'd1);
        chk("tp_jxx_t", pc, 64'h100);
        step(1, 1, I_JXX, 0, 0, 64'h100, 64'h0B, 3'd1);
        chk("tp_stall", pc, 64'h100);

        // call / ret pair
        nop_op(I_CALL, 0, 64'h200, 64'h15);
        chk("tp_top_15", ras_top, 64'h15);
        nop_op(I_RET, 64'h15, 0, 0);
        chk("tp_ret_hit", ret_hit, 1);

        // overflow and full unwind, then underflow
        for (int i = 1; i <= 9; i++) nop_op(I_CALL, 0, 64'h300 + i, 64'(i));
        chk("tp_ovf", ras_overflow, 1);
        chk("tp_cnt8", ras_count, 8);
        for (int i = 9; i >= 2; i--) begin
            nop_op(I_RET, 64'(i), 0, 0);
            chk("tp_unwind_hit", ret_hit, 1);
        end
        nop_op(I_RET, 64'h1, 0, 0);
        chk("tp_underflow_hit", ret_hit, 0);
        chk("tp_underflow_cnt", ras_count, 0);
        nop_op(I_RET, 64'h0, 0, 0);  // empty stack with val_m == 0 must miss

        // perf counters: 3 rets, 2 matching
        step(0, 0, I_NOP, 0, 0, 0, 0, 3'd1);
        nop_op(I_CALL, 0, 64'h500, 64'h40);
        nop_op(I_CALL, 0, 64'h500, 64'h50);
        nop_op(I_CALL, 0, 64'h500, 64'h60);
        nop_op(I_RET, 64'h60, 0, 0);
        nop_op(I_RET, 64'h51, 0, 0);
        nop_op(I_RET, 64'h40, 0, 0);
`ifdef RAS_PERF_EN
        chk("tp_tot3", ret_total, 3);
        chk("tp_hits2", ret_hits, 2);
`else
        chk("tp_tot0", ret_total, 0);
        chk("tp_hits0", ret_hits, 0);
`endif

        // non-AOK status, bad icode, halt, reset during stall
        nop_op(I_NOP, 0, 0, 64'h70);
        step(1, 0, I_NOP, 0, 0, 0, 64'h80, 3'd3);
        chk("tp_stat_adr", pc, 64'h70);
        step(1, 0, I_CALL, 0, 0, 64'h90, 64'h91, 3'd2);
        nop_op(4'hE, 0, 0, 64'h88);
        chk("tp_bad", bad_icode, 1);
        nop_op(I_NOP, 0, 0, 64'h74);
        nop_op(I_HALT, 0, 0, 64'h123);
        chk("tp_halt_pc", pc, 64'h123);
        step(1, 0, I_JXX, 1, 0, 64'h999, 64'h124, 3'd1);
        chk("tp_halt_hold", pc, 64'h123);
        step(0, 1, I_JXX, 1, 0, 64'h999, 64'h124, 3'd2);
        chk("tp_rst_stall", halted, 0);

        // randomized traffic with a small address pool so rets hit
        for (int n = 0; n < 400; n++) begin
            bit          r, s;
            logic [3:0]  ic;
            logic [2:0]  st;
            r  = ($urandom_range(0, 39) != 0);
            s  = ($urandom_range(0, 7) == 0);
            ic = 4'($urandom_range(0, 15));
            if (ic == I_HALT && $urandom_range(0, 3) != 0) ic = I_CALL;
            if ($urandom_range(0, 2) == 0) ic = I_RET;
            st = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            step(r, s, ic, 1'($urandom_range(0, 1)), 64'($urandom_range(16, 19)),
                 64'($urandom_range(256, 511)), 64'($urandom_range(16, 19)), st);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
